mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU issued from EX. Its hi/lo outputs feed the EX/WB result-select multiplexer for MFHI/MFLO. Its busy output goes to the hazard unit, which stalls any younger MFHI/MFLO or multiply/divide while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 4)
MUL_LAT, 2, cycles in MUL state (1..4); the product is computed combinationally and registered through MUL_LAT stages

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  issue operation this cycle (EX valid, not stalled)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (dividend / multiplicand)
b  input  WIDTH  rt operand (divisor / multiplier)
hi_we  input  1  MTHI write
lo_we  input  1  MTLO write
wdata  input  WIDTH  MTHI/MTLO data
flush  input  1  abort in-flight operation (branch/exception squash)
busy  output  1  operation in flight (registered)
done  output  1  one-cycle pulse: HI/LO just updated by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, async): state IDLE; hi=0, lo=0, busy=0, done=0; counters and partial remainder cleared. Reset mid-operation discards the operation with no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start: capture a, b and op. Go to MUL (op[1]=0) or DIV (op[1]=1). busy=1 from the next cycle.
- MUL: stays MUL_LAT cycles. HI/LO take {hi,lo} = a*b (2*WIDTH; signed for MULT, unsigned for MULTU) at the clock edge ending the last MUL cycle. Then go to IDLE.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (1 cycle): apply signs for DIV. Quotient is negative iff the operand signs differ. Remainder takes the dividend's sign. HI=remainder, LO=quotient written at the end of FIX. Then go to IDLE.
- Latency, start edge to HI/LO visible: MUL_LAT+1 cycles for multiply, WIDTH+2 cycles for divide. busy is high MUL_LAT (mul) or WIDTH+1 (div) cycles.
- done is high for exactly the first IDLE cycle in which new HI/LO are visible. It is 0 otherwise, including after flush.
- Divide by zero: LO = all ones, HI = dividend, same latency.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- start while busy: ignored (the hazard unit guarantees this never happens; assertion in bench).
- hi_we/lo_we: honoured only in IDLE without start, taking effect next edge. Ignored while busy. If asserted together with start, start wins and the writes are dropped.
- flush: checked before start in every state. It returns to IDLE the next cycle with busy=0, and HI/LO are unchanged. flush with start in IDLE means the start is ignored.
- hi/lo change only at the end of MUL or FIX, on an accepted MTHI/MTLO, or on reset.

Decomposition:
- Package mdu_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum, localparam CNT_W = $clog2(WIDTH+1).
- Sub-module mdu_divider: an iterative unsigned restoring divider. It takes start, dividend, divisor and abort, and returns quotient, remainder and valid after WIDTH cycles.
- The top level owns sign handling, the multiplier pipeline, the FSM and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> after 3 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIVU a=100, b=7 -> busy high 33 cycles, lo=14, hi=2 at cycle 34; DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Corner divides: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xCAFEF00D in IDLE -> hi updated next cycle. MTLO during an active DIV -> lo unchanged, and the DIV result overwrites lo at completion.
- flush at cycle 10 of a DIV -> busy=0 next cycle, hi/lo hold their prior values, done never pulses; a new MULT 3*4 then gives lo=12, hi=0.
- rst_n low for one cycle mid-MUL -> hi=lo=0, busy=0 immediately (asynchronously); no done pulse after rst_n is released.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and counter sizing for the HI/LO multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    // Counter width able to hold values 0..w
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(32);

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative unsigned restoring divider, one quotient bit per cycle
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   trial;
    logic             ok;

    // Shift the next dividend bit into the partial remainder and try subtracting the divisor
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign ok    = ~trial[WIDTH];

    assign quotient  = quo;
    assign remainder = rem;

    // Load on start, then iterate WIDTH times; valid pulses the cycle after the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            valid <= 1'b0;
        end else if (abort) begin
            run   <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
            cnt   <= CW'(WIDTH);
            run   <= 1'b1;
            valid <= 1'b0;
        end else if (run) begin
            rem   <= ok ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo   <= {quo[WIDTH-2:0], ok};
            cnt   <= cnt - CW'(1);
            run   <= cnt != CW'(1);
            valid <= cnt == CW'(1);
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS multiply/divide unit owning the architectural HI/LO registers
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               accept, last, fin;
    logic               sgn_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   quo, rem, fix_q, fix_r;
    logic               div_valid, neg_q, neg_r, dz;
    logic [2*WIDTH-1:0] prod_s, prod_u, prod;
    logic [2*WIDTH-1:0] pipe [MUL_LAT];
    logic [WIDTH-1:0]   hi_nx, lo_nx;

    assign accept = start & ~flush & (state == S_IDLE);
    assign last   = cnt == CW'(1);
    assign busy   = state != S_IDLE;

    // Sign-extended operands give the signed product modulo 2^(2*WIDTH)
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod   = op[0] ? prod_u : prod_s;

    // The divider works on magnitudes; signs are restored in FIX
    assign a_mag = (~op[0] & a[WIDTH-1]) ? -a : a;
    assign b_mag = (~op[0] & b[WIDTH-1]) ? -b : b;

    assign neg_q = sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    assign neg_r = sgn_r & a_r[WIDTH-1];
    assign dz    = b_r == '0;
    assign fix_q = neg_q ? -quo : quo;
    assign fix_r = neg_r ? -rem : rem;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept & op[1]),
        .abort     (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .valid     (div_valid)
    );

    // Multiplier pipeline: the product of the issue-cycle operands reaches the last stage after MUL_LAT edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // State, cycle counter, captured operands, HI/LO and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sgn_r <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? (op[1] ? CW'(WIDTH) : CW'(MUL_LAT)) : (busy ? cnt - CW'(1) : cnt);
            if (accept) begin
                sgn_r <= ~op[0];
                a_r   <= a;
                b_r   <= b;
            end
            hi    <= hi_nx;
            lo    <= lo_nx;
            done  <= fin;
        end
    end

    // Next state: flush always wins, then the per-state sequencing
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nx = start ? (op[1] ? S_DIV : S_MUL) : S_IDLE;
                S_MUL:   state_nx = last ? S_IDLE : S_MUL;
                S_DIV:   state_nx = last ? S_FIX : S_DIV;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // HI/LO update: MTHI/MTLO only in quiet IDLE, results at the end of MUL or FIX
    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        fin   = 1'b0;
        if (!flush) begin
            case (state)
                S_IDLE: begin
                    hi_nx = (hi_we & ~start) ? wdata : hi;
                    lo_nx = (lo_we & ~start) ? wdata : lo;
                end
                S_MUL: begin
                    if (last) begin
                        {hi_nx, lo_nx} = pipe[MUL_LAT-1];
                        fin            = 1'b1;
                    end
                end
                S_FIX: begin
                    if (div_valid) begin
                        hi_nx = dz ? a_r : fix_r;
                        lo_nx = dz ? '1 : fix_q;
                        fin   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo with directed, hand-computed vectors
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, hi_we, lo_we, flush;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb [$];

    mdu_hilo #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                chk("sb_hilo", {hi, lo}, sb.pop_front());
            end
        end
    end

    // The hazard unit never issues while busy
    always @(posedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1)
            assert (start !== 1'b1) else $error("start issued while busy");
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [63:0] e);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] e, input int exp_busy);
        int n;
        issue(o, x, y, 1'b1, e);
        wait_done(n);
        chk({nm, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        @(negedge clk);
        chk({nm, "_done_once"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult",  2'b00, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE}, 2);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'hFFFFFFFE}, 2);
        run_op("divu",  2'b11, 32'd100,      32'd7, {32'd2, 32'd14}, 33);
        chk("divu_lo_direct", 64'(lo), 64'd14);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
        run_op("div_zero_s", 2'b10, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 33);
        run_op("divu_zero", 2'b11, 32'h00001234, 32'd0, {32'h00001234, 32'hFFFFFFFF}, 33);

        // MTHI in IDLE lands on the next edge and leaves LO alone
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hCAFEF00D);
        chk("mthi_lo", 64'(lo), 64'hFFFFFFFF);

        // MTLO during a divide is dropped; the divide result then overwrites both
        issue(2'b11, 32'd50, 32'd5, 1'b1, {32'd0, 32'd10});
        repeat (3) @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_busy_lo", 64'(lo), 64'hFFFFFFFF);
        wait_done(n);
        @(negedge clk);
        chk("mtlo_after_lo", 64'(lo), 64'd10);

        // Flush in the tenth DIV cycle: back to idle, HI/LO untouched, no done
        issue(2'b10, 32'd1000, 32'd3, 1'b0, 64'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {hi, lo}, {32'd0, 32'd10});
        run_op("mult_3x4", 2'b00, 32'd3, 32'd4, {32'd0, 32'd12}, 2);

        // Asynchronous reset during a multiply
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h00000055;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi2_hi", 64'(hi), 64'h55);
        issue(2'b00, 32'd5, 32'd6, 1'b0, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_after_hilo", {hi, lo}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
